// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: carries the EX result into MEM and parks the
// intermediate product and cycle counter of a multi-cycle EX operation.
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_reg_we,
  input  logic [31:0] ex_alu_res,
  input  logic        ex_hi_we,
  input  logic        ex_lo_we,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [31:0] ex_inst,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_waddr,
  output logic        mem_reg_we,
  output logic [31:0] mem_alu_res,
  output logic        mem_hi_we,
  output logic        mem_lo_we,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic [31:0] mem_inst,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  logic [4:0]  r_waddr;
  logic        r_reg_we;
  logic [31:0] r_alu_res;
  logic        r_hi_we;
  logic        r_lo_we;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_inst;
  logic [63:0] r_hilo;
  logic [1:0]  r_cnt;

  logic w_hold;
  logic w_bubble;
  logic w_unused_stall;

  // MEM stalled wins regardless of the EX bit; only EX stalled injects a bubble.
  assign w_hold         = stall[4];
  assign w_bubble       = stall[3] & ~stall[4];
  assign w_unused_stall = ^{stall[5], stall[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_waddr   <= 5'd0;
      r_reg_we  <= 1'b0;
      r_alu_res <= 32'd0;
      r_hi_we   <= 1'b0;
      r_lo_we   <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_inst    <= 32'd0;
      r_hilo    <= 64'd0;
      r_cnt     <= 2'd0;
    end else if (w_hold) begin
      r_waddr   <= r_waddr;
      r_reg_we  <= r_reg_we;
      r_alu_res <= r_alu_res;
      r_hi_we   <= r_hi_we;
      r_lo_we   <= r_lo_we;
      r_hi      <= r_hi;
      r_lo      <= r_lo;
      r_inst    <= r_inst;
      r_hilo    <= r_hilo;
      r_cnt     <= r_cnt;
    end else if (w_bubble) begin
      // The bubble carries no writes; EX's partial product is parked for resume.
      r_waddr   <= 5'd0;
      r_reg_we  <= 1'b0;
      r_alu_res <= 32'd0;
      r_hi_we   <= 1'b0;
      r_lo_we   <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_inst    <= 32'd0;
      r_hilo    <= hilo_i;
      r_cnt     <= cnt_i;
    end else begin
      r_waddr   <= ex_waddr;
      r_reg_we  <= ex_reg_we;
      r_alu_res <= ex_alu_res;
      r_hi_we   <= ex_hi_we;
      r_lo_we   <= ex_lo_we;
      r_hi      <= ex_hi;
      r_lo      <= ex_lo;
      r_inst    <= ex_inst;
      r_hilo    <= 64'd0;
      r_cnt     <= 2'd0;
    end
  end

  assign mem_waddr   = r_waddr;
  assign mem_reg_we  = r_reg_we;
  assign mem_alu_res = r_alu_res;
  assign mem_hi_we   = r_hi_we;
  assign mem_lo_we   = r_lo_we;
  assign mem_hi      = r_hi;
  assign mem_lo      = r_lo;
  assign mem_inst    = r_inst;
  assign hilo_o      = r_hilo;
  assign cnt_o       = r_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios plus randomized traffic checked
// against a mode-level reference model of the pipeline register.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  ex_waddr;
  logic        ex_reg_we;
  logic [31:0] ex_alu_res;
  logic        ex_hi_we;
  logic        ex_lo_we;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [31:0] ex_inst;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_waddr;
  logic        mem_reg_we;
  logic [31:0] mem_alu_res;
  logic        mem_hi_we;
  logic        mem_lo_we;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [31:0] mem_inst;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_waddr(ex_waddr), .ex_reg_we(ex_reg_we), .ex_alu_res(ex_alu_res),
    .ex_hi_we(ex_hi_we), .ex_lo_we(ex_lo_we), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_inst(ex_inst), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_waddr(mem_waddr), .mem_reg_we(mem_reg_we), .mem_alu_res(mem_alu_res),
    .mem_hi_we(mem_hi_we), .mem_lo_we(mem_lo_we), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_inst(mem_inst), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model: one record of what MEM should see
  typedef struct {
    logic [4:0]  waddr;
    logic        reg_we;
    logic [31:0] alu_res;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] inst;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } out_t;

  out_t m;
  out_t snap;

  function automatic out_t zero_out();
    out_t z;
    z = '{default: '0};
    return z;
  endfunction

  // One edge of the model: reset, else HOLD / BUBBLE / PASS decided by stall[4:3].
  task automatic model_edge();
    out_t n;
    if (rst) begin
      n = zero_out();
    end else if (stall[4]) begin
      n = m;
    end else if (stall[3]) begin
      n = zero_out();
      n.hilo = hilo_i;
      n.cnt  = cnt_i;
    end else begin
      n = '{ex_waddr, ex_reg_we, ex_alu_res, ex_hi_we, ex_lo_we,
            ex_hi, ex_lo, ex_inst, 64'd0, 2'd0};
    end
    m = n;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".waddr"},   64'(mem_waddr),   64'(m.waddr));
    check({tag, ".reg_we"},  64'(mem_reg_we),  64'(m.reg_we));
    check({tag, ".alu_res"}, 64'(mem_alu_res), 64'(m.alu_res));
    check({tag, ".hi_we"},   64'(mem_hi_we),   64'(m.hi_we));
    check({tag, ".lo_we"},   64'(mem_lo_we),   64'(m.lo_we));
    check({tag, ".hi"},      64'(mem_hi),      64'(m.hi));
    check({tag, ".lo"},      64'(mem_lo),      64'(m.lo));
    check({tag, ".inst"},    64'(mem_inst),    64'(m.inst));
    check({tag, ".hilo"},    hilo_o,           m.hilo);
    check({tag, ".cnt"},     64'(cnt_o),       64'(m.cnt));
  endtask

  // driver tasks
  task automatic clear_inputs();
    ex_waddr = '0; ex_reg_we = 1'b0; ex_alu_res = '0; ex_hi_we = 1'b0;
    ex_lo_we = 1'b0; ex_hi = '0; ex_lo = '0; ex_inst = '0; hilo_i = '0; cnt_i = '0;
  endtask

  task automatic rand_inputs();
    ex_waddr   = 5'($urandom_range(0, 31));
    ex_reg_we  = 1'($urandom_range(0, 1));
    ex_alu_res = $urandom;
    ex_hi_we   = 1'($urandom_range(0, 1));
    ex_lo_we   = 1'($urandom_range(0, 1));
    ex_hi      = $urandom;
    ex_lo      = $urandom;
    ex_inst    = $urandom;
    hilo_i     = {$urandom, $urandom};
    cnt_i      = 2'($urandom_range(0, 3));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    stall = 6'd0;
    m = zero_out();
    rand_inputs();
    cycle("reset");
    check("reset.all_zero", {hilo_o[63:2], cnt_o}, 64'd0);

    // pass-through
    rst = 1'b0;
    clear_inputs();
    ex_waddr = 5'd8; ex_reg_we = 1'b1; ex_alu_res = 32'h0000_1234;
    cycle("pass");
    check("pass.waddr_lit", 64'(mem_waddr), 64'd8);
    check("pass.alu_lit", 64'(mem_alu_res), 64'h1234);

    // multi-cycle madd: bubble parks product, pass clears it and captures HI
    clear_inputs();
    stall = 6'b001111; hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
    ex_reg_we = 1'b1; ex_hi_we = 1'b1;
    cycle("madd1");
    check("madd1.hilo_lit", hilo_o, 64'h0000_0001_0000_0002);
    check("madd1.we_lit", {mem_reg_we, mem_hi_we, mem_lo_we}, 64'd0);
    hilo_i = 64'h0000_0003_0000_0004; cnt_i = 2'd2;
    cycle("madd_bubble2");
    clear_inputs();
    stall = 6'd0; ex_hi_we = 1'b1; ex_hi = 32'h5;
    hilo_i = 64'hFFFF_FFFF_FFFF_FFFF; cnt_i = 2'd3;
    cycle("madd2");
    check("madd2.hi_lit", {mem_hi_we, mem_hi}, {1'b1, 32'h5});
    check("madd2.hilo_clear", {hilo_o, cnt_o}, 66'd0);

    // hold with a parked product, then hold after DEADBEEF load
    stall = 6'b001000; hilo_i = 64'h1234_5678_9ABC_DEF0; cnt_i = 2'd2;
    cycle("park");
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin rand_inputs(); cycle("hold_park"); end
    check("hold_park.cnt_lit", 64'(cnt_o), 64'd2);
    clear_inputs();
    stall = 6'd0; ex_alu_res = 32'hDEAD_BEEF;
    cycle("load_beef");
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin rand_inputs(); cycle("hold"); end
    check("hold.alu_lit", 64'(mem_alu_res), 64'hDEAD_BEEF);

    // reset priority over hold
    stall = 6'b001000; cnt_i = 2'd1;
    cycle("pre_rst");
    rst = 1'b1; stall = 6'b011111; rand_inputs();
    cycle("rst_prio");
    check("rst_prio.cnt_lit", 64'(cnt_o), 64'd0);
    rst = 1'b0;

    // illegal stall behaves as hold
    stall = 6'd0; rand_inputs();
    cycle("pre_illegal");
    snap = m;
    stall = 6'b010000; rand_inputs(); ex_reg_we = ~snap.reg_we;
    cycle("illegal");
    check("illegal.reg_we_kept", 64'(mem_reg_we), 64'(snap.reg_we));
    check("illegal.alu_kept", 64'(mem_alu_res), 64'(snap.alu_res));

    // ignored stall bits
    clear_inputs();
    stall = 6'b100111; ex_waddr = 5'd8; ex_reg_we = 1'b1; ex_alu_res = 32'h0000_1234;
    cycle("ignored_bits");
    check("ignored.waddr_lit", 64'(mem_waddr), 64'd8);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: stall = {$urandom_range(0, 1) == 1, 2'b00, 3'($urandom_range(0, 7))};
        1: stall = {$urandom_range(0, 1) == 1, 2'b01, 3'($urandom_range(0, 7))};
        default: stall = 6'($urandom_range(0, 63));
      endcase
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
